// File: rtl/adc_fifo_writer.sv
// adc_fifo_writer: write-side capture controller for the ADC sample FIFO.
// After an arm command it waits for a rising edge on trig. It then decimates
// the ADC stream and offers exactly len_l candidate samples to the FIFO write
// port. Candidates that arrive while the FIFO is almost full are dropped and
// counted in a saturating overflow counter.
//
// FIFO write handshake: wr_en is a one-cycle push strobe with no ready return.
// wr_data is valid only in a cycle where wr_en=1, and holds its last value
// otherwise. Backpressure comes only through fifo_almst_full, which is sampled
// in the same cycle as the candidate. A candidate seen while it is high is
// never written.
module adc_fifo_writer #(
   parameter int DATA_WIDTH  = 14,
   parameter int LEN_WIDTH   = 16,
   parameter int DECIM_WIDTH = 8,
   parameter int OVF_WIDTH   = 16
) (
   input  logic                   clk_a,
   input  logic                   rst,
   input  logic                   arm,
   input  logic                   abort,
   input  logic                   trig,
   input  logic [LEN_WIDTH-1:0]   cap_len,
   input  logic [DECIM_WIDTH-1:0] decim,
   input  logic                   adc_valid,
   input  logic [DATA_WIDTH-1:0]  adc_data,
   input  logic                   fifo_almst_full,
   output logic                   wr_en,
   output logic [DATA_WIDTH-1:0]  wr_data,
   output logic                   busy,
   output logic                   done,
   output logic [LEN_WIDTH-1:0]   cand_cnt,
   output logic [OVF_WIDTH-1:0]   ovf_cnt,
   output logic [1:0]             dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARMED   = 2'd1,
      S_CAPTURE = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic                   trig_dly_q;
   logic [LEN_WIDTH-1:0]   len_q, len_d;
   logic [DECIM_WIDTH-1:0] decim_q, decim_d;
   logic [DECIM_WIDTH-1:0] dec_cnt_q, dec_cnt_d;
   logic [LEN_WIDTH-1:0]   cand_cnt_q, cand_cnt_d;
   logic [OVF_WIDTH-1:0]   ovf_cnt_q, ovf_cnt_d;
   logic                   wr_en_q, wr_en_d;
   logic [DATA_WIDTH-1:0]  wr_data_q, wr_data_d;

   logic trig_edge;
   logic arm_ok;
   logic cand_hit;
   logic last_cand;
   logic ovf_sat;

   // An arm with a zero length is treated as no command at all.
   assign trig_edge = trig & ~trig_dly_q;
   assign arm_ok    = arm & (cap_len != '0);
   assign cand_hit  = adc_valid & (dec_cnt_q == decim_q);
   assign last_cand = (cand_cnt_q == (len_q - LEN_WIDTH'(1)));
   assign ovf_sat   = (ovf_cnt_q == {OVF_WIDTH{1'b1}});

   // Trigger delay register: runs in every state so the edge is always fresh.
   always_ff @(posedge clk_a) begin
      if (rst) begin
         trig_dly_q <= 1'b0;
      end else begin
         trig_dly_q <= trig;
      end
   end

   // State, latched configuration, counters and the registered write port.
   always_ff @(posedge clk_a) begin
      if (rst) begin
         state_q    <= S_IDLE;
         len_q      <= '0;
         decim_q    <= '0;
         dec_cnt_q  <= '0;
         cand_cnt_q <= '0;
         ovf_cnt_q  <= '0;
         wr_en_q    <= 1'b0;
         wr_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         decim_q    <= decim_d;
         dec_cnt_q  <= dec_cnt_d;
         cand_cnt_q <= cand_cnt_d;
         ovf_cnt_q  <= ovf_cnt_d;
         wr_en_q    <= wr_en_d;
         wr_data_q  <= wr_data_d;
      end
   end

   // Next-state logic. Abort wins over everything except reset. It also
   // kills any write the current cycle would have produced.
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      decim_d    = decim_q;
      dec_cnt_d  = dec_cnt_q;
      cand_cnt_d = cand_cnt_q;
      ovf_cnt_d  = ovf_cnt_q;
      wr_en_d    = 1'b0;
      wr_data_d  = wr_data_q;

      if (abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (arm_ok) begin
                  len_d      = cap_len;
                  decim_d    = decim;
                  cand_cnt_d = '0;
                  ovf_cnt_d  = '0;
                  state_d    = S_ARMED;
               end
            end

            S_ARMED: begin
               // The sample in the edge cycle itself is not eligible.
               if (trig_edge) begin
                  dec_cnt_d = '0;
                  state_d   = S_CAPTURE;
               end
            end

            S_CAPTURE: begin
               if (adc_valid) begin
                  if (cand_hit) begin
                     dec_cnt_d  = '0;
                     cand_cnt_d = cand_cnt_q + LEN_WIDTH'(1);
                     if (!fifo_almst_full) begin
                        wr_en_d   = 1'b1;
                        wr_data_d = adc_data;
                     end else if (!ovf_sat) begin
                        ovf_cnt_d = ovf_cnt_q + OVF_WIDTH'(1);
                     end
                     // Dropped candidates count toward the length too, so the
                     // capture window depends only on the valid-sample timing.
                     if (last_cand) begin
                        state_d = S_DONE;
                     end
                  end else begin
                     dec_cnt_d = dec_cnt_q + DECIM_WIDTH'(1);
                  end
               end
            end

            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   assign wr_en     = wr_en_q;
   assign wr_data   = wr_data_q;
   assign busy      = (state_q == S_ARMED) || (state_q == S_CAPTURE);
   assign done      = (state_q == S_DONE);
   assign cand_cnt  = cand_cnt_q;
   assign ovf_cnt   = ovf_cnt_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_adc_fifo_writer.sv
// tb_adc_fifo_writer: directed scenario tests for adc_fifo_writer.
// The DUT is built with OVF_WIDTH=2 so that saturation of the overflow
// counter can be reached in a short run.
module tb_adc_fifo_writer;

   localparam int DW = 14;
   localparam int LW = 16;
   localparam int DCW = 8;
   localparam int OW = 2;

   logic           clk_a = 1'b0;
   logic           rst = 1'b1;
   logic           arm = 1'b0;
   logic           abort = 1'b0;
   logic           trig = 1'b0;
   logic [LW-1:0]  cap_len = '0;
   logic [DCW-1:0] decim = '0;
   logic           adc_valid = 1'b0;
   logic [DW-1:0]  adc_data = '0;
   logic           fifo_almst_full = 1'b0;
   logic           wr_en;
   logic [DW-1:0]  wr_data;
   logic           busy;
   logic           done;
   logic [LW-1:0]  cand_cnt;
   logic [OW-1:0]  ovf_cnt;
   logic [1:0]     dbg_state;

   int checks = 0;
   int errors = 0;
   int data_val = 0;

   logic [DW-1:0] got_q[$];
   int            cyc_q[$];
   logic [DW-1:0] exp_q[$];

   adc_fifo_writer #(
      .DATA_WIDTH(DW), .LEN_WIDTH(LW), .DECIM_WIDTH(DCW), .OVF_WIDTH(OW)
   ) dut (
      .clk_a(clk_a), .rst(rst), .arm(arm), .abort(abort), .trig(trig),
      .cap_len(cap_len), .decim(decim), .adc_valid(adc_valid),
      .adc_data(adc_data), .fifo_almst_full(fifo_almst_full),
      .wr_en(wr_en), .wr_data(wr_data), .busy(busy), .done(done),
      .cand_cnt(cand_cnt), .ovf_cnt(ovf_cnt), .dbg_state(dbg_state)
   );

   // Clock generation
   always #5 clk_a = ~clk_a;

   // One clock; outputs are sampled 1 time unit after the rising edge
   task automatic step();
      @(posedge clk_a);
      #1;
   endtask

   task automatic do_arm(input int len, input int dec);
      cap_len = LW'(len);
      decim   = DCW'(dec);
      arm     = 1'b1;
      step();
      arm     = 1'b0;
   endtask

   // Drive n cycles of ADC stream and record every FIFO write.
   // toggle: valid only on even cycles. almst_full is high for cycles af_lo..af_hi.
   // The data ramp advances only after a valid sample.
   task automatic run(input int n, input bit toggle, input int af_lo, input int af_hi);
      got_q.delete();
      cyc_q.delete();
      for (int i = 0; i < n; i++) begin
         adc_valid       = toggle ? (i % 2 == 0) : 1'b1;
         adc_data        = DW'(data_val);
         fifo_almst_full = (i >= af_lo) && (i <= af_hi);
         step();
         if (adc_valid) data_val++;
         if (wr_en) begin
            got_q.push_back(wr_data);
            cyc_q.push_back(i);
         end
      end
      adc_valid       = 1'b0;
      fifo_almst_full = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      checks++;
      if (wr_en !== 1'b0 || wr_data !== '0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: wr_en=%b wr_data=%0d busy=%b done=%b, expected all 0",
                  wr_en, wr_data, busy, done);
      end
      checks++;
      if (cand_cnt !== '0 || ovf_cnt !== '0 || dbg_state !== 2'd0) begin
         errors++;
         $display("FAIL reset_counters: cand=%0d ovf=%0d state=%0d, expected 0 0 0",
                  cand_cnt, ovf_cnt, dbg_state);
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_basic_capture();
      trig = 1'b0;
      do_arm(4, 0);
      checks++;
      if (busy !== 1'b1 || dbg_state !== 2'd1) begin
         errors++;
         $display("FAIL basic_armed: busy=%b state=%0d, expected 1 1", busy, dbg_state);
      end
      run(3, 0, -1, -1);
      trig = 1'b1;
      data_val = 100;
      run(10, 0, -1, -1);
      exp_q = '{14'd101, 14'd102, 14'd103, 14'd104};
      checks++;
      if (got_q.size() !== exp_q.size()) begin
         errors++;
         $display("FAIL basic_count: got %0d writes, expected %0d", got_q.size(), exp_q.size());
      end else begin
         foreach (exp_q[i]) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
               errors++;
               $display("FAIL basic_data[%0d]: got %0d expected %0d", i, got_q[i], exp_q[i]);
            end
         end
         checks++;
         if (cyc_q[3] - cyc_q[0] !== 3) begin
            errors++;
            $display("FAIL basic_consecutive: span %0d expected 3", cyc_q[3] - cyc_q[0]);
         end
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || cand_cnt !== 16'd4 || ovf_cnt !== 2'd0) begin
         errors++;
         $display("FAIL basic_final: done=%b busy=%b cand=%0d ovf=%0d, expected 1 0 4 0",
                  done, busy, cand_cnt, ovf_cnt);
      end
      checks++;
      if (wr_data !== 14'd104) begin
         errors++;
         $display("FAIL basic_hold: wr_data=%0d expected 104", wr_data);
      end
   endtask

   task automatic test_decimation(input bit toggle);
      trig = 1'b0;
      do_arm(3, 2);
      run(2, 0, -1, -1);
      trig = 1'b1;
      data_val = 100;
      run(toggle ? 24 : 13, toggle, -1, -1);
      exp_q = '{14'd103, 14'd106, 14'd109};
      checks++;
      if (got_q.size() !== 3) begin
         errors++;
         $display("FAIL decim_count(toggle=%0d): got %0d writes, expected 3", toggle, got_q.size());
      end else begin
         foreach (exp_q[i]) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
               errors++;
               $display("FAIL decim_data[%0d](toggle=%0d): got %0d expected %0d",
                        i, toggle, got_q[i], exp_q[i]);
            end
         end
         checks++;
         if (cyc_q[1] - cyc_q[0] !== (toggle ? 6 : 3) || cyc_q[2] - cyc_q[1] !== (toggle ? 6 : 3)) begin
            errors++;
            $display("FAIL decim_spacing(toggle=%0d): got %0d,%0d expected %0d",
                     toggle, cyc_q[1] - cyc_q[0], cyc_q[2] - cyc_q[1], toggle ? 6 : 3);
         end
      end
      checks++;
      if (done !== 1'b1 || cand_cnt !== 16'd3) begin
         errors++;
         $display("FAIL decim_final(toggle=%0d): done=%b cand=%0d, expected 1 3", toggle, done, cand_cnt);
      end
   endtask

   task automatic test_backpressure();
      trig = 1'b0;
      do_arm(6, 0);
      run(2, 0, -1, -1);
      trig = 1'b1;
      data_val = 100;
      // Cycle 0 is the edge cycle; candidates 3 and 4 fall in cycles 3 and 4
      run(9, 0, 3, 4);
      exp_q = '{14'd101, 14'd102, 14'd105, 14'd106};
      checks++;
      if (got_q.size() !== 4) begin
         errors++;
         $display("FAIL bp_count: got %0d writes, expected 4", got_q.size());
      end else begin
         foreach (exp_q[i]) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
               errors++;
               $display("FAIL bp_data[%0d]: got %0d expected %0d", i, got_q[i], exp_q[i]);
            end
         end
      end
      checks++;
      if (ovf_cnt !== 2'd2 || cand_cnt !== 16'd6 || done !== 1'b1) begin
         errors++;
         $display("FAIL bp_final: ovf=%0d cand=%0d done=%b, expected 2 6 1", ovf_cnt, cand_cnt, done);
      end
   endtask

   task automatic test_ignored_events();
      abort = 1'b1;
      step();
      abort = 1'b0;
      trig  = 1'b0;
      step();
      trig = 1'b1;
      step();
      checks++;
      if (dbg_state !== 2'd0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL ign_trig_idle: state=%0d busy=%b done=%b, expected 0 0 0", dbg_state, busy, done);
      end
      do_arm(2, 0);
      do_arm(5, 3);
      checks++;
      if (dbg_state !== 2'd1) begin
         errors++;
         $display("FAIL ign_rearm: state=%0d expected 1", dbg_state);
      end
      run(4, 0, -1, -1);
      checks++;
      if (got_q.size() !== 0 || dbg_state !== 2'd1) begin
         errors++;
         $display("FAIL ign_trig_held: writes=%0d state=%0d, expected 0 1", got_q.size(), dbg_state);
      end
      trig = 1'b0;
      step();
      trig = 1'b1;
      data_val = 100;
      run(8, 0, -1, -1);
      checks++;
      if (got_q.size() !== 2 || cand_cnt !== 16'd2 || done !== 1'b1) begin
         errors++;
         $display("FAIL ign_length: writes=%0d cand=%0d done=%b, expected 2 2 1",
                  got_q.size(), cand_cnt, done);
      end else begin
         checks++;
         if (got_q[0] !== 14'd101 || got_q[1] !== 14'd102) begin
            errors++;
            $display("FAIL ign_data: got %0d,%0d expected 101,102", got_q[0], got_q[1]);
         end
      end
   endtask

   task automatic test_abort();
      trig = 1'b0;
      do_arm(8, 0);
      run(2, 0, -1, -1);
      trig = 1'b1;
      data_val = 100;
      run(3, 0, -1, -1);
      checks++;
      if (got_q.size() !== 2) begin
         errors++;
         $display("FAIL abort_pre_writes: got %0d expected 2", got_q.size());
      end
      abort     = 1'b1;
      adc_valid = 1'b1;
      adc_data  = DW'(data_val);
      step();
      abort     = 1'b0;
      adc_valid = 1'b0;
      checks++;
      if (wr_en !== 1'b0 || dbg_state !== 2'd0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL abort_state: wr_en=%b state=%0d busy=%b done=%b, expected 0 0 0 0",
                  wr_en, dbg_state, busy, done);
      end
      checks++;
      if (cand_cnt !== 16'd2) begin
         errors++;
         $display("FAIL abort_cand_hold: cand=%0d expected 2", cand_cnt);
      end
   endtask

   task automatic test_reset_mid_capture();
      trig = 1'b0;
      do_arm(8, 0);
      run(2, 0, -1, -1);
      trig = 1'b1;
      data_val = 100;
      run(3, 0, -1, -1);
      rst       = 1'b1;
      adc_valid = 1'b1;
      adc_data  = DW'(data_val);
      step();
      rst       = 1'b0;
      adc_valid = 1'b0;
      checks++;
      if (wr_en !== 1'b0 || wr_data !== '0 || busy !== 1'b0 || done !== 1'b0 ||
          cand_cnt !== '0 || ovf_cnt !== '0 || dbg_state !== 2'd0) begin
         errors++;
         $display("FAIL rst_mid: wr_en=%b data=%0d busy=%b done=%b cand=%0d ovf=%0d state=%0d, expected all 0",
                  wr_en, wr_data, busy, done, cand_cnt, ovf_cnt, dbg_state);
      end
   endtask

   task automatic test_rearm_saturation();
      trig = 1'b0;
      do_arm(5, 0);
      run(2, 0, -1, -1);
      trig = 1'b1;
      data_val = 100;
      run(8, 0, 0, 20);
      checks++;
      if (got_q.size() !== 0 || ovf_cnt !== 2'd3 || cand_cnt !== 16'd5 || done !== 1'b1) begin
         errors++;
         $display("FAIL sat_final: writes=%0d ovf=%0d cand=%0d done=%b, expected 0 3 5 1",
                  got_q.size(), ovf_cnt, cand_cnt, done);
      end
      trig = 1'b0;
      do_arm(0, 0);
      checks++;
      if (done !== 1'b1 || dbg_state !== 2'd3 || cand_cnt !== 16'd5 || ovf_cnt !== 2'd3) begin
         errors++;
         $display("FAIL rearm_zero: done=%b state=%0d cand=%0d ovf=%0d, expected 1 3 5 3",
                  done, dbg_state, cand_cnt, ovf_cnt);
      end
      do_arm(2, 0);
      checks++;
      if (dbg_state !== 2'd1 || busy !== 1'b1 || done !== 1'b0 || cand_cnt !== '0 || ovf_cnt !== '0) begin
         errors++;
         $display("FAIL rearm_two: state=%0d busy=%b done=%b cand=%0d ovf=%0d, expected 1 1 0 0 0",
                  dbg_state, busy, done, cand_cnt, ovf_cnt);
      end
      trig = 1'b1;
      data_val = 200;
      run(6, 0, -1, -1);
      checks++;
      if (got_q.size() !== 2 || done !== 1'b1) begin
         errors++;
         $display("FAIL rearm_capture: writes=%0d done=%b, expected 2 1", got_q.size(), done);
      end else begin
         checks++;
         if (got_q[0] !== 14'd201 || got_q[1] !== 14'd202) begin
            errors++;
            $display("FAIL rearm_data: got %0d,%0d expected 201,202", got_q[0], got_q[1]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_capture();
      test_decimation(1'b0);
      test_decimation(1'b1);
      test_backpressure();
      test_ignored_events();
      test_abort();
      test_reset_mid_capture();
      test_rearm_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/adc_fifo_writer.md
Name: adc_fifo_writer

Overview:
- Write-side capture controller for the sample FIFO, clocked in the ADC (write) domain clk_a.
- Arms on command, waits for a trigger rising edge, then decimates the ADC sample stream.
- Pushes exactly cap_len candidate samples into the FIFO write port, with almost-full backpressure and overflow accounting.
- Feeds wr_en/wr_data of the async FIFO; the read side and the DAC path drain it.

Parameters:
DATA_WIDTH, 14, sample and FIFO word width
LEN_WIDTH, 16, width of capture length and candidate counter
DECIM_WIDTH, 8, width of decimation ratio
OVF_WIDTH, 16, width of saturating overflow counter

Ports:
clk_a  in  1  ADC-domain clock, all logic on rising edge
rst  in  1  reset, synchronous, active-high
arm  in  1  pulse; latches cap_len/decim, enters ARMED (from IDLE or DONE)
abort  in  1  forces IDLE from any state; priority over all but rst
trig  in  1  trigger level; rising edge starts capture
cap_len  in  LEN_WIDTH  candidates per capture, sampled on accepted arm
decim  in  DECIM_WIDTH  keep one of every decim+1 valid samples, sampled on accepted arm
adc_valid  in  1  adc_data valid this cycle
adc_data  in  DATA_WIDTH  ADC sample
fifo_almst_full  in  1  FIFO almost-full flag (backpressure)
wr_en  out  1  FIFO write strobe, registered
wr_data  out  DATA_WIDTH  FIFO write data, registered
busy  out  1  state is ARMED or CAPTURE
done  out  1  state is DONE (level)
cand_cnt  out  LEN_WIDTH  candidates taken in current capture
ovf_cnt  out  OVF_WIDTH  candidates dropped for backpressure, saturating

Behaviour:
- Reset: state IDLE; wr_en=0, wr_data=0, cand_cnt=0, ovf_cnt=0, dec_cnt=0, trig_d=0, latched len/decim=0; busy=0, done=0.
- trig_d is trig registered every cycle, all states. Edge = trig & ~trig_d.
- IDLE:
  - arm with cap_len!=0: latch len_l=cap_len, decim_l=decim; clear cand_cnt, ovf_cnt; -> ARMED.
  - arm with cap_len==0: ignored, stay IDLE.
- ARMED: edge -> CAPTURE, dec_cnt<=0. The sample in the edge cycle is not captured; the first eligible sample is in the first CAPTURE cycle.
- CAPTURE, on a cycle with adc_valid=1:
  - dec_cnt!=decim_l: dec_cnt++ and sample discarded (no count).
  - dec_cnt==decim_l: dec_cnt<=0; sample is a candidate; cand_cnt++.
  - Candidate with fifo_almst_full=0 in that same cycle: next cycle wr_en=1, wr_data=adc_data (1-cycle latency).
  - Candidate with fifo_almst_full=1: dropped, wr_en stays 0, ovf_cnt++ saturating at all-ones.
  - A dropped candidate still counts toward len_l, so the capture window is time-deterministic.
- decim=0: every valid sample is a candidate.
- adc_valid=0: no counter changes.
- CAPTURE exit: in the cycle the candidate with cand_cnt==len_l-1 is taken, -> DONE. That final write (if accepted) appears on wr_en the following cycle, the same cycle done first reads 1.
- DONE:
  - done=1, cand_cnt/ovf_cnt hold for readout.
  - arm with cap_len!=0: re-latch, clear counters, -> ARMED. arm with cap_len==0 is ignored.
- arm while ARMED or CAPTURE: ignored; latched values are unchanged.
- trig edges outside ARMED: ignored.
- abort (any state): -> IDLE next cycle; wr_en=0 next cycle; a pending write from the abort cycle is suppressed; counters hold.
- wr_en is high for at most 1 cycle per candidate; wr_data holds its last value while wr_en=0.
- Arithmetic:
  - cand_cnt compares against len_l; len_l=2^LEN_WIDTH-1 is the maximum capture.
  - dec_cnt is DECIM_WIDTH bits and never wraps past decim_l.
- No fifo_full input: almost-full margin (>=2 entries) is the only overflow guard. Integrators must size ALMST so in-flight writes cannot overrun the FIFO.

Test Plan:
- Basic capture: arm, cap_len=4, decim=0, adc_valid=1 always, adc_data ramp from 100, trig edge at cycle 10. Expect wr_en high 4 consecutive cycles with data 101..104 (the first CAPTURE-cycle sample onward, one cycle latency), done=1 after, cand_cnt=4, ovf_cnt=0.
- Decimation: cap_len=3, decim=2, continuous valid ramp. Expect writes of every third sample (offsets 2, 5, 8 from capture start), then DONE. With adc_valid toggling 1/0, same three data values at doubled spacing.
- Backpressure: cap_len=6, decim=0, fifo_almst_full=1 for candidates 3-4. Expect 4 writes (candidates 1, 2, 5, 6), ovf_cnt=2, cand_cnt=6, done=1.
- Ignored events: trig edge in IDLE, then arm while ARMED with different cap_len, then trig held high through arm. Expect no writes; capture starts only on a fresh 0->1 trig; length equals the first latched cap_len.
- Abort and reset mid-capture: abort after 2 of 8 writes. Expect IDLE next cycle, wr_en=0 even with a candidate in the abort cycle, busy=0, done=0. Repeat with rst: all outputs 0 the cycle after.
- Re-arm and saturation: from DONE, arm with cap_len=0 (ignored, stays DONE), then arm with cap_len=2 (counters cleared, ARMED). With OVF_WIDTH=2, 5 dropped candidates leave ovf_cnt=3.
